game_ctrl: RTL

Top-level game sequencer for the minesweeper core. Drives `screen_state` into `map_genarate`, holds the GENERATE phase for a fixed number of cycles, then tracks player reveals and flags against `map_mine_o`. Decides WIN/LOSE and runs the play timer. Sits between the input decoder (button pulses, cursor) and the map generator and display logic.

---
 rtl/game_ctrl_pkg.sv | 19 +
 rtl/game_timer.sv | 51 +++++
 rtl/game_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared constants and state encoding for the minesweeper game sequencer.
package game_ctrl_pkg;

  localparam int MAP_WIDTH    = 5;
  localparam int MAP_HEIGHT   = 3;
  localparam int MAP_CELLS    = MAP_WIDTH * MAP_HEIGHT;
  localparam int MAP_MINE_NUM = 3;
  localparam int TIMER_MAX    = 999;

  // Screen states; the numeric values are what map_genarate decodes.
  typedef enum logic [2:0] {
    SCR_IDLE = 3'd0,
    SCR_GEN  = 3'd1,
    SCR_PLAY = 3'd2,
    SCR_WIN  = 3'd3,
    SCR_LOSE = 3'd4
  } scr_state_e;

endpackage

// File: rtl/game_timer.sv
// Play timer: divides the clock down to seconds and counts them, stopping at TIMER_MAX.
import game_ctrl_pkg::*;

module game_timer #(
  parameter int CLK_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  output logic [9:0] sec_o
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    sec_q, sec_d;

  // Clear wins over run; the prescaler wraps on its last count and bumps the seconds.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (clr) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (run) begin
      if (presc_q == PW'(CLK_PER_SEC - 1)) begin
        presc_d = '0;
        if (sec_q != 10'(TIMER_MAX)) begin
          sec_d = sec_q + 10'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  assign sec_o = sec_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> GEN -> PLAY -> WIN/LOSE, tracking reveals and flags per cell.
import game_ctrl_pkg::*;

module game_ctrl #(
  parameter int GEN_CYCLES  = 5,
  parameter int CLK_PER_SEC = 100_000_000,
  parameter int MINE_NUM    = MAP_MINE_NUM,
  parameter int X_W         = $clog2(MAP_WIDTH),
  parameter int Y_W         = $clog2(MAP_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_start_i,
  input  logic                 btn_reveal_i,
  input  logic                 btn_flag_i,
  input  logic [X_W-1:0]       cursor_x_i,
  input  logic [Y_W-1:0]       cursor_y_i,
  input  logic [MAP_CELLS-1:0] map_mine_i,
  output logic [2:0]           screen_state_o,
  output logic [MAP_CELLS-1:0] revealed_o,
  output logic [MAP_CELLS-1:0] flag_o,
  output logic [9:0]           timer_o
);

  localparam int GW       = $clog2(GEN_CYCLES + 1);
  localparam int SW       = $clog2(MAP_CELLS + 1);
  localparam int IDX_W    = $clog2(MAP_CELLS);
  localparam int SAFE_NUM = MAP_CELLS - MINE_NUM;

  scr_state_e           state_q, state_d;
  logic [GW-1:0]        gen_cnt_q, gen_cnt_d;
  logic [MAP_CELLS-1:0] rev_q, rev_d;
  logic [MAP_CELLS-1:0] flag_q, flag_d;
  logic [SW-1:0]        safe_q, safe_d;
  logic                 timer_clr;
  logic                 cell_ok;
  logic [IDX_W-1:0]     cell_idx;

  // Cursor to bitmap index; an off-map cursor must not alias onto a real cell.
  always_comb begin
    cell_ok  = (int'(cursor_x_i) < MAP_WIDTH) && (int'(cursor_y_i) < MAP_HEIGHT);
    cell_idx = IDX_W'(cursor_y_i) * IDX_W'(MAP_WIDTH) + IDX_W'(cursor_x_i);
  end

  // Next-state logic for the FSM, GEN countdown, bitmaps and safe-cell count.
  always_comb begin
    state_d   = state_q;
    gen_cnt_d = gen_cnt_q;
    rev_d     = rev_q;
    flag_d    = flag_q;
    safe_d    = safe_q;
    timer_clr = 1'b0;
    case (state_q)
      SCR_IDLE, SCR_WIN, SCR_LOSE: begin
        if (btn_start_i) begin
          state_d   = SCR_GEN;
          gen_cnt_d = GW'(GEN_CYCLES - 1);
          rev_d     = '0;
          flag_d    = '0;
          safe_d    = '0;
          timer_clr = 1'b1;
        end
      end
      SCR_GEN: begin
        if (gen_cnt_q == '0) begin
          state_d = SCR_PLAY;
        end else begin
          gen_cnt_d = gen_cnt_q - GW'(1);
        end
      end
      SCR_PLAY: begin
        if (cell_ok && btn_reveal_i) begin
          if (!rev_q[cell_idx] && !flag_q[cell_idx]) begin
            rev_d[cell_idx] = 1'b1;
            if (map_mine_i[cell_idx]) begin
              state_d = SCR_LOSE;
            end else begin
              safe_d = safe_q + SW'(1);
              if (safe_d == SW'(SAFE_NUM)) begin
                state_d = SCR_WIN;
              end
            end
          end
        end else if (cell_ok && btn_flag_i) begin
          if (!rev_q[cell_idx]) begin
            flag_d[cell_idx] = ~flag_q[cell_idx];
          end
        end
      end
      default: state_d = SCR_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCR_IDLE;
      gen_cnt_q <= '0;
      rev_q     <= '0;
      flag_q    <= '0;
      safe_q    <= '0;
    end else begin
      state_q   <= state_d;
      gen_cnt_q <= gen_cnt_d;
      rev_q     <= rev_d;
      flag_q    <= flag_d;
      safe_q    <= safe_d;
    end
  end

  game_timer #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == SCR_PLAY),
    .clr   (timer_clr),
    .sec_o (timer_o)
  );

  assign screen_state_o = state_q;
  assign revealed_o     = rev_q;
  assign flag_o         = flag_q;

endmodule
